// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Imported by mem_arb_rr and mem_arbiter.
package mem_arb_pkg;

  localparam int CNT_W = 8;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } arb_state_e;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_e;

  // The wait counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin selector with its last-grant history register.
// History moves only when the parent FSM actually issues a grant.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grantEn_i,
  output logic gntAny_o,
  output gnt_e gntSel_o
);

  gnt_e last_q, last_d;

  always_comb begin
    gntAny_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      gntSel_o = (last_q == GNT_M0) ? GNT_M1 : GNT_M0;
    end else if (req1_i) begin
      gntSel_o = GNT_M1;
    end else begin
      gntSel_o = GNT_M0;
    end
    last_d = last_q;
    if (grantEn_i && gntAny_o) begin
      last_d = gntSel_o;
    end
  end

  // Resetting to m1 makes m0 the winner of the first tie.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      last_q <= GNT_M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two native memory masters onto one slave port.
// Flow is IDLE -> BUSY -> RESP; slow slaves are cut off by a wait timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e       state_q, state_d;
  gnt_e             owner_q, owner_d;
  logic             sValid_q, sValid_d;
  logic [31:0]      sAddr_q, sAddr_d;
  logic [31:0]      sWdata_q, sWdata_d;
  logic [3:0]       sWstrb_q, sWstrb_d;
  logic [31:0]      m0Rdata_q, m0Rdata_d;
  logic [31:0]      m1Rdata_q, m1Rdata_d;
  logic             m0Ready_q, m0Ready_d;
  logic             m1Ready_q, m1Ready_d;
  logic             timeoutErr_q, timeoutErr_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

  logic        grantEn;
  logic        gntAny;
  gnt_e        gntSel;
  logic        timedOut;
  logic [31:0] respData;

  mem_arb_rr u_rr (
    .clock     (clock),
    .resetn    (resetn),
    .req0_i    (m0_valid),
    .req1_i    (m1_valid),
    .grantEn_i (grantEn),
    .gntAny_o  (gntAny),
    .gntSel_o  (gntSel)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    sValid_d     = sValid_q;
    sAddr_d      = sAddr_q;
    sWdata_d     = sWdata_q;
    sWstrb_d     = sWstrb_q;
    m0Rdata_d    = m0Rdata_q;
    m1Rdata_d    = m1Rdata_q;
    m0Ready_d    = 1'b0;
    m1Ready_d    = 1'b0;
    timeoutErr_d = 1'b0;
    waitCnt_d    = waitCnt_q;
    grantEn      = 1'b0;
    timedOut     = 1'b0;
    respData     = s_rdata;

    unique case (state_q)
      ST_IDLE: begin
        if (gntAny) begin
          grantEn   = 1'b1;
          owner_d   = gntSel;
          sValid_d  = 1'b1;
          waitCnt_d = '0;
          state_d   = ST_BUSY;
          if (gntSel == GNT_M1) begin
            sAddr_d  = m1_addr;
            sWdata_d = m1_wdata;
            sWstrb_d = m1_wstrb;
          end else begin
            sAddr_d  = m0_addr;
            sWdata_d = m0_wdata;
            sWstrb_d = m0_wstrb;
          end
        end
      end

      // A slave handshake in the timeout cycle still counts as real data.
      ST_BUSY: begin
        timedOut = !s_ready && (waitCnt_q >= TIMEOUT_VAL);
        respData = s_ready ? s_rdata : ERR_RDATA;
        if (s_ready || timedOut) begin
          sValid_d     = 1'b0;
          timeoutErr_d = timedOut;
          state_d      = ST_RESP;
          if (owner_q == GNT_M1) begin
            m1Rdata_d = respData;
            m1Ready_d = 1'b1;
          end else begin
            m0Rdata_d = respData;
            m0Ready_d = 1'b1;
          end
        end else begin
          waitCnt_d = satInc(waitCnt_q);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        sValid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= GNT_M0;
      sValid_q     <= 1'b0;
      sAddr_q      <= '0;
      sWdata_q     <= '0;
      sWstrb_q     <= '0;
      m0Rdata_q    <= '0;
      m1Rdata_q    <= '0;
      m0Ready_q    <= 1'b0;
      m1Ready_q    <= 1'b0;
      timeoutErr_q <= 1'b0;
      waitCnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      sValid_q     <= sValid_d;
      sAddr_q      <= sAddr_d;
      sWdata_q     <= sWdata_d;
      sWstrb_q     <= sWstrb_d;
      m0Rdata_q    <= m0Rdata_d;
      m1Rdata_q    <= m1Rdata_d;
      m0Ready_q    <= m0Ready_d;
      m1Ready_q    <= m1Ready_d;
      timeoutErr_q <= timeoutErr_d;
      waitCnt_q    <= waitCnt_d;
    end
  end

  assign s_valid     = sValid_q;
  assign s_addr      = sAddr_q;
  assign s_wdata     = sWdata_q;
  assign s_wstrb     = sWstrb_q;
  assign m0_rdata    = m0Rdata_q;
  assign m1_rdata    = m1Rdata_q;
  assign m0_ready    = m0Ready_q;
  assign m1_ready    = m1Ready_q;
  assign timeout_err = timeoutErr_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max slave wait cycles before forced completion (range 2..255).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEADBEEF, read data returned on timeout.
REQ-003 SHALL have port clock, input, 1, the only clock; all logic on posedge.
REQ-004 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports m0_valid in 1, m0_ready out 1, m0_addr in 32, m0_wdata in 32, m0_wstrb in 4, m0_rdata out 32: master 0 native memory port; wstrb==0 means read.
REQ-006 SHALL have ports m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata, with the same directions, widths and meaning: master 1 port.
REQ-007 SHALL have ports s_valid out 1, s_ready in 1, s_addr out 32, s_wdata out 32, s_wstrb out 4, s_rdata in 32: shared slave memory port.
REQ-008 SHALL have port timeout_err, output, 1, one-cycle pulse on forced completion.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-010 IDLE: if any mX_valid, SHALL pick a winner, register its addr/wdata/wstrb onto s_*, set s_valid=1, and go to BUSY next cycle.
REQ-011 Arbitration SHALL be round-robin: when both valid, grant the master not granted last; a lone requester wins regardless.
REQ-012 BUSY: on s_ready=1, SHALL clear s_valid, capture s_rdata into the winner's mX_rdata, pulse the winner's mX_ready for exactly one cycle, and go to RESP.
REQ-013 s_valid SHALL never be high in the cycle after s_ready was sampled high, so the slave does not see a repeat request.
REQ-014 BUSY: a wait counter SHALL increment each cycle s_ready=0.
REQ-015 When the wait counter reaches TIMEOUT_CYCLES, SHALL clear s_valid, drive mX_rdata=ERR_RDATA, pulse mX_ready and timeout_err for one cycle, and go to RESP.
REQ-016 RESP: SHALL hold all ready outputs low for one cycle, then go to IDLE; a new grant therefore starts no earlier than the cycle after RESP.
REQ-017 Latency: request sampled at cycle N gives s_valid at N+1; s_ready sampled at K gives mX_ready at K+1; earliest next s_valid is at K+3.
REQ-018 s_addr, s_wdata and s_wstrb SHALL stay stable while s_valid=1.
REQ-019 A master dropping mX_valid during BUSY SHALL NOT abort the slave access; the transaction completes and the response pulse is still issued.
REQ-020 The non-granted master's mX_ready SHALL stay 0 and its mX_rdata SHALL hold its previous value.
REQ-021 The wait counter SHALL be 8 bits, cleared on entry to BUSY, and saturate, never wrapping.
REQ-022 If s_ready and the timeout occur in the same cycle, s_ready SHALL win: real data is returned and timeout_err=0.
REQ-023 The arbitration history (last-grant) SHALL update only on a grant, not on timeout or reset release.

Reset
REQ-024 When resetn=0 at a posedge: state=IDLE, s_valid=0, m0_ready=m1_ready=0, timeout_err=0, wait counter=0, s_addr/s_wdata/s_wstrb/mX_rdata=0, last-grant=m1 (so m0 wins the first tie).
REQ-025 Reset during BUSY SHALL abandon the access with no ready pulse; s_valid SHALL be 0 in the cycle after the reset edge.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the state enum, the ERR_RDATA default, and the counter width constant.
REQ-027 Round-robin selection plus the last-grant register SHALL be one sub-module, mem_arb_rr; the FSM and datapath SHALL live in mem_arbiter.

Verification
REQ-028 Single read: m0 reads addr 0x100; slave returns 0x12345678 with ready 2 cycles later -> m0_ready one cycle, m0_rdata=0x12345678, m1_ready=0.
REQ-029 Tie: m0 and m1 both valid from reset -> m0 granted first, then m1; repeat both valid -> strict alternation m0,m1,m0,m1 over 4 grants.
REQ-030 Write pass-through: m1 writes 0x20000000 data 123456789 wstrb 4'hF -> s_* match exactly, s_valid drops the cycle after s_ready, m1_ready pulses once.
REQ-031 Timeout: m0 reads, s_ready held 0 -> after 64 wait cycles, m0_rdata=0xDEADBEEF, m0_ready and timeout_err pulse together for one cycle.
REQ-032 Reset mid-BUSY: resetn=0 one cycle while s_valid=1 -> s_valid=0 next cycle, no mX_ready pulse, and the next tie grants m0.
REQ-033 Coincident s_ready and timeout at count 64 -> slave data is returned and timeout_err=0.
